// File: rtl/bram_stream_reader_pkg.sv
// Shared types and helpers for the BRAM read-side stream sequencer and its
// output FIFO.
package bram_stream_reader_pkg;

    localparam int PKG_RAM_WIDTH = 18;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } rd_state_e;

    // Same address-width rule as the BRAM wrapper: never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

    typedef struct packed {
        logic                     last;
        logic [PKG_RAM_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// Synchronous first-word-fall-through FIFO. A push into an empty FIFO is shown
// on dout in the same cycle, so a push and pop together always both succeed.
module sync_fwft_fifo
    import bram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4,
    localparam int PW = clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             bypass;
    logic             do_write;
    logic             do_read;

    // With nothing stored, an incoming word that is popped at once never lands in memory.
    always_comb begin
        bypass   = (count == '0);
        empty    = bypass && !push;
        full     = (count == CW'(DEPTH));
        do_write = push && (bypass ? !pop : (!full || pop));
        do_read  = pop && !bypass;
        if (!bypass)   dout = mem[rd_ptr];
        else if (push) dout = din;
        else           dout = '0;
    end

    always_ff @(posedge clka) begin
        if (rsta || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_read)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_write) - CW'(do_read);
        end
    end

    always_ff @(posedge clka) begin
        if (do_write && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bram_stream_reader.sv
// BRAM read-port sequencer: issues one burst of reads under a credit limit and
// re-times the returned words into a valid/ready stream through a small FIFO.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int RAM_WIDTH    = PKG_RAM_WIDTH,
    parameter int RAM_DEPTH    = 1024,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4,
    localparam int ADDR_W = clog2(RAM_DEPTH),
    localparam int CNT_W  = clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      length,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic                 ram_en,
    output logic                 ram_regce,
    input  logic [RAM_WIDTH-1:0] ram_rdata,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready
);

    localparam int EW = $bits(fifo_entry_t);

    generate
        if (RAM_WIDTH != PKG_RAM_WIDTH) begin : g_bad_width
            $error("RAM_WIDTH must match the entry width in bram_stream_reader_pkg");
        end
        if (((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (FIFO_DEPTH < READ_LATENCY + 1)) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of 2 and at least READ_LATENCY+1");
        end
    endgenerate

    rd_state_e               state;
    rd_state_e               state_nxt;
    logic [ADDR_W-1:0]       addr_q;
    logic [ADDR_W:0]         remaining;
    logic [READ_LATENCY-1:0] vld_pipe;
    logic [READ_LATENCY-1:0] last_pipe;
    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        fifo_count;
    logic                    tail_vld;
    logic                    issue;
    logic                    abort_act;
    logic                    credit_ok;
    logic                    drain_done;
    logic                    fifo_push;
    logic                    fifo_empty;
    logic                    fifo_full;
    fifo_entry_t             fifo_din;
    fifo_entry_t             fifo_dout;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CNT_W'(vld_pipe[i]);
    end

    // Every word already stored or in flight owns a FIFO slot, so the FIFO cannot overflow.
    always_comb begin
        tail_vld  = vld_pipe[READ_LATENCY-1];
        abort_act = abort && (state == ISSUE || state == DRAIN);
        credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W+1)'(FIFO_DEPTH);
        issue     = (state == ISSUE) && !abort && (remaining != '0) && credit_ok;
        fifo_push = tail_vld && !abort_act;
        fifo_din  = '{last: last_pipe[READ_LATENCY-1], data: ram_rdata};
        // True when the FIFO and read pipe will both be empty after this cycle.
        drain_done = (inflight == CNT_W'(tail_vld)) &&
                     (((fifo_count == '0) && (!fifo_push || m_ready)) ||
                      ((fifo_count == CNT_W'(1)) && !fifo_push && m_ready));
    end

    always_ff @(posedge clka) begin
        if (rsta) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = (length == '0) ? FINISH : ISSUE;
            ISSUE: begin
                if (abort)                                         state_nxt = FINISH;
                else if (issue && (remaining == (ADDR_W+1)'(1)))   state_nxt = DRAIN;
            end
            DRAIN:  if (abort || drain_done) state_nxt = FINISH;
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        done   = (state == FINISH);
        ram_en = issue;
    end

    assign ram_regce = !rsta;
    assign ram_addr  = addr_q;

    always_ff @(posedge clka) begin
        if (rsta) begin
            addr_q    <= '0;
            remaining <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            if (state == IDLE && start && length != '0) begin
                addr_q    <= base_addr;
                remaining <= length;
            end else if (issue) begin
                addr_q    <= (addr_q == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
                remaining <= remaining - 1'b1;
            end
            // Clearing the pipe makes words still in the BRAM pipeline drop on arrival.
            if (abort_act) begin
                vld_pipe  <= '0;
                last_pipe <= '0;
            end else begin
                for (int i = READ_LATENCY - 1; i > 0; i--) begin
                    vld_pipe[i]  <= vld_pipe[i-1];
                    last_pipe[i] <= last_pipe[i-1];
                end
                vld_pipe[0]  <= issue;
                last_pipe[0] <= issue && (remaining == (ADDR_W+1)'(1));
            end
        end
    end

    sync_fwft_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clka  (clka),
        .rsta  (rsta),
        .push  (fifo_push),
        .pop   (m_ready),
        .flush (abort_act),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_dout.data;
    assign m_last  = fifo_dout.last;

    assert property (@(posedge clka) disable iff (rsta) !(fifo_push && fifo_full && !m_ready))
        else $error("output FIFO overflow");

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomised bench for bram_stream_reader: a BRAM model feeds the DUT and a
// burst-level scoreboard checks addresses, stream words, busy and done every cycle.
module tb_bram_stream_reader;

    localparam int RW = 18;
    localparam int RD = 1024;
    localparam int AW = 10;
    localparam int FD = 4;

    logic          clka = 1'b0;
    logic          rsta = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          m_ready = 1'b1;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, ram_en, ram_regce, m_valid, m_last;
    logic [AW-1:0] ram_addr;
    logic [RW-1:0] m_data;
    logic [RW-1:0] ram_rdata = '0;
    logic [RW-1:0] s1 = '0;
    logic [RW-1:0] mem [RD];

    always #5 clka = ~clka;

    bram_stream_reader #(
        .RAM_WIDTH(RW), .RAM_DEPTH(RD), .READ_LATENCY(2), .FIFO_DEPTH(FD)
    ) dut (
        .clka(clka), .rsta(rsta), .start(start), .base_addr(base_addr), .length(length),
        .abort(abort), .busy(busy), .done(done), .ram_addr(ram_addr), .ram_en(ram_en),
        .ram_regce(ram_regce), .ram_rdata(ram_rdata), .m_data(m_data), .m_valid(m_valid),
        .m_last(m_last), .m_ready(m_ready)
    );

    // Two-stage BRAM read: array read on enable, then the output register.
    always @(posedge clka) begin
        if (ram_en)    s1 <= mem[ram_addr];
        if (ram_regce) ram_rdata <= s1;
    end

    typedef struct { logic [RW-1:0] d; logic l; } word_t;

    int errs = 0, checks = 0, cyc = 0;
    word_t exp_q[$];
    bit mbusy = 0, done_due = 0, aborted = 0, prev_stall = 0, prev_abort = 0;
    int issued = 0, accepted = 0, cur_len = 0;
    int exp_addr = 0;
    logic [RW-1:0] prev_data = '0;
    int addr_log[$];
    logic [RW-1:0] data_log[$];
    int first_en, last_en, first_val, last_acc, done_cyc, n_done, busy_cnt, pre_acc_issues;
    int rmode = 0, stall_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic clear_logs();
        addr_log.delete(); data_log.delete();
        first_en = -1; last_en = -1; first_val = -1; last_acc = -1; done_cyc = -1;
        n_done = 0; busy_cnt = 0; pre_acc_issues = 0;
    endtask

    // Scoreboard: one burst = LEN words from BASE modulo RD, last flag on the final one.
    always @(negedge clka) begin
        bit fin_now, abort_now, hs;
        cyc++;
        if (rsta) begin
            chk("regce_in_reset", ram_regce, 0);
            exp_q.delete();
            mbusy = 0; done_due = 0; aborted = 0; prev_stall = 0; prev_abort = 0;
            issued = 0; accepted = 0; cur_len = 0;
        end else begin
            fin_now   = done_due;
            abort_now = abort && mbusy && !fin_now;
            hs        = 0;
            chk("done", done, fin_now);
            chk("busy", busy, mbusy);
            chk("regce", ram_regce, 1);
            if (busy) busy_cnt++;
            if (ram_en) begin
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                addr_log.push_back(int'(ram_addr));
                if (data_log.size() == 0) pre_acc_issues++;
                chk("issue_allowed", (mbusy && !aborted && !abort_now && !fin_now && issued < cur_len), 1);
                chk("ram_addr", ram_addr, exp_addr);
                exp_addr = (exp_addr + 1) % RD;
                issued++;
                chk("credit", (issued - accepted) <= FD, 1);
            end
            if (m_valid) begin
                if (first_val < 0) first_val = cyc;
                if (exp_q.size() == 0) chk("valid_without_word", m_valid, 0);
                else begin
                    chk("m_data", m_data, exp_q[0].d);
                    chk("m_last", m_last, exp_q[0].l);
                end
                if (prev_stall && !prev_abort) chk("stable_data", m_data, prev_data);
                if (m_ready && exp_q.size() > 0) begin
                    hs = 1;
                    data_log.push_back(m_data);
                    void'(exp_q.pop_front());
                    accepted++;
                    last_acc = cyc;
                end
            end else if (prev_stall && !prev_abort) begin
                chk("stable_valid", m_valid, 1);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_abort = abort_now;
            if (done) begin n_done++; done_cyc = cyc; end
            done_due = 0;
            if (fin_now) begin
                mbusy = 0; aborted = 0;
            end else if (mbusy) begin
                if (abort_now) begin
                    exp_q.delete(); aborted = 1; done_due = 1;
                end else if (hs && exp_q.size() == 0) begin
                    done_due = 1;
                end
            end else if (start) begin
                mbusy = 1; cur_len = int'(length); issued = 0; accepted = 0;
                exp_addr = int'(base_addr);
                for (int i = 0; i < cur_len; i++)
                    exp_q.push_back('{d: mem[(int'(base_addr) + i) % RD], l: (i == cur_len - 1)});
                if (cur_len == 0) done_due = 1;
            end
        end
    end

    task automatic step();
        @(posedge clka);
        #1;
        case (rmode)
            1: begin
                m_ready = (stall_cnt < 10) ? 1'b0 : ((stall_cnt - 10) % 2 == 0);
                stall_cnt++;
            end
            2: m_ready = ($urandom_range(0, 3) != 0);
            3: ;
            default: m_ready = 1'b1;
        endcase
    endtask

    task automatic wait_done(input int maxc);
        int k = 0;
        while (n_done == 0 && k < maxc) begin step(); k++; end
        repeat (3) step();
        chk("done_once", n_done, 1);
    endtask

    task automatic run_burst(input int b, input int l, input int mode);
        clear_logs();
        rmode = mode; stall_cnt = 0;
        base_addr = AW'(b); length = (AW+1)'(l); start = 1'b1;
        step();
        start = 1'b0;
        wait_done(3000);
        rmode = 0;
    endtask

    task automatic rand_burst(input int b, input int l, input int ab);
        int k = 0;
        clear_logs();
        rmode = 2;
        base_addr = AW'(b); length = (AW+1)'(l); start = 1'b1;
        step();
        start = 1'b0;
        while (n_done == 0 && k < 5000) begin
            abort = (k == ab);
            // A start while busy must be ignored.
            start = (k == 2) && busy;
            if (start) begin
                base_addr = AW'($urandom_range(0, RD - 1));
                length = (AW+1)'($urandom_range(1, 9));
            end
            step();
            k++;
        end
        abort = 1'b0; start = 1'b0;
        repeat (3) step();
        chk("rand_done_once", n_done, 1);
        rmode = 0;
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_ram_en"}, ram_en, 0);
        chk({p, "_ram_addr"}, ram_addr, 0);
        chk({p, "_m_valid"}, m_valid, 0);
        chk({p, "_m_last"}, m_last, 0);
        chk({p, "_m_data"}, m_data, 0);
        chk({p, "_regce"}, ram_regce, 0);
    endtask

    initial begin
        int wait_k;
        for (int i = 0; i < RD; i++) mem[i] = RW'($urandom);
        for (int i = 0; i < 4; i++) mem[i] = RW'(18'h100 + i);
        mem[1022] = 18'h1FE;
        mem[1023] = 18'h1FF;
        clear_logs();

        repeat (3) step();
        chk_all_zero("reset");
        rsta = 1'b0;
        repeat (2) step();

        // Basic burst from 0.
        run_burst(0, 4, 0);
        chk("s1_issues", addr_log.size(), 4);
        chk("s1_en_span", last_en - first_en, 3);
        chk("s1_latency", first_val - first_en, 2);
        chk("s1_words", data_log.size(), 4);
        if (data_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("s1_data", data_log[i], 18'h100 + i);
        chk("s1_done_after_last", done_cyc - last_acc, 1);

        // Address wrap at the top of the RAM.
        run_burst(1022, 4, 0);
        chk("s2_issues", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            chk("s2_addr0", addr_log[0], 1022);
            chk("s2_addr1", addr_log[1], 1023);
            chk("s2_addr2", addr_log[2], 0);
            chk("s2_addr3", addr_log[3], 1);
        end
        if (data_log.size() == 4) begin
            chk("s2_data0", data_log[0], 18'h1FE);
            chk("s2_data3", data_log[3], 18'h101);
        end

        // Backpressure: 10 stalled cycles then alternating ready.
        run_burst(100, 16, 1);
        chk("s3_stall_issues", pre_acc_issues, 4);
        chk("s3_words", data_log.size(), 16);

        // Zero-length burst.
        run_burst(5, 0, 0);
        chk("s4_busy_cycles", busy_cnt, 1);
        chk("s4_no_issue", addr_log.size(), 0);
        chk("s4_no_valid", first_val, -1);

        // Abort after three accepted words.
        clear_logs();
        base_addr = AW'(200); length = (AW+1)'(8); start = 1'b1;
        step();
        start = 1'b0;
        wait_k = 0;
        while (data_log.size() < 3 && wait_k < 100) begin step(); wait_k++; end
        chk("s5_three_accepted", data_log.size(), 3);
        rmode = 3; m_ready = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        chk("s5_valid_drop", m_valid, 0);
        chk("s5_no_issue", ram_en, 0);
        wait_done(50);
        chk("s5_words_kept", data_log.size(), 3);
        rmode = 0;
        run_burst(300, 5, 0);
        if (data_log.size() > 0) chk("s5_restart_first", data_log[0], mem[300]);
        chk("s5_restart_words", data_log.size(), 5);

        // Reset in the middle of a burst.
        clear_logs();
        base_addr = AW'(400); length = (AW+1)'(12); start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rsta = 1'b1;
        step();
        chk_all_zero("midrst");
        rsta = 1'b0;
        repeat (5) step();
        chk("s6_no_done", n_done, 0);
        run_burst(0, 2, 0);
        chk("s6_latency", first_val - first_en, 2);
        if (data_log.size() == 2) begin
            chk("s6_data0", data_log[0], 18'h100);
            chk("s6_data1", data_log[1], 18'h101);
        end
        chk("s6_done_after_last", done_cyc - last_acc, 1);

        // Randomised bursts with random backpressure and occasional aborts.
        for (int t = 0; t < 25; t++) begin
            int b, l, ab;
            b  = $urandom_range(0, RD - 1);
            l  = $urandom_range(0, 40);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : -1;
            rand_burst(b, l, ab);
        end
        rand_burst(17, RD, -1);
        chk("full_ram_words", data_log.size(), RD);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
